load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the RV32I execute stage and the byte-addressable 1 KB data memory, directly upstream of the memory.
- Accepts one load/store request at a time over a valid/ready handshake and decodes funct3 into the memory's 2-bit write-enable code.
- Checks alignment and address range, sign- or zero-extends load data, and returns a registered response over a second valid/ready handshake.

Parameters:
- MEM_BYTES, 1024: size of the attached data memory in bytes; accesses whose last byte is at or above this address fault.
- ADDR_W, 32: width of request and memory addresses.

Ports:
- Clk  in  1  system clock; all state changes on the rising edge.
- Rst  in  1  asynchronous, active-high reset.
- Req_Valid  in  1  request present.
- Req_Ready  out  1  unit can accept a request; high only in IDLE.
- Req_Store  in  1  1 = store, 0 = load.
- Req_Funct3  in  3  RV32I funct3 (LB=0, LH=1, LW=2, LBU=4, LHU=5; SB=0, SH=1, SW=2).
- Req_Addr  in  32  byte address.
- Req_Wdata  in  32  store data, with the LSB-aligned byte or halfword holding the stored value.
- Rsp_Valid  out  1  response present; held until accepted.
- Rsp_Ready  in  1  consumer accepts the response.
- Rsp_Rdata  out  32  extended load data; 0 for stores and errors.
- Rsp_Misaligned  out  1  alignment error, access suppressed.
- Rsp_Fault  out  1  out-of-range address or illegal funct3, access suppressed.
- Mem_RD_Addr  out  32  memory read address.
- Mem_WR_Addr  out  32  memory write address.
- Mem_Din  out  32  memory write data.
- Mem_WE  out  2  00 none, 01 byte, 10 half, 11 word.
- Mem_Dout  in  32  combinational little-endian read data from memory at Mem_RD_Addr.

Behaviour:
- Reset values: state IDLE; Req_Ready=1; Rsp_Valid=0; Rsp_Rdata=0; Rsp_Misaligned=0; Rsp_Fault=0; Mem_WE=00; address, data and request registers 0.
- Reset is asynchronous. An assertion during ACCESS drops Mem_WE to 00 immediately, so no write occurs at the next edge. An assertion during RESP discards the pending response.

State machine, three states:
- IDLE
  - Req_Ready=1.
  - On Req_Valid at an edge, latch Store, Funct3, Addr and Wdata, and evaluate errors.
  - No error: go to ACCESS.
  - Any error: go directly to RESP with the matching flag set and Rdata=0. The memory is never touched.
- ACCESS, exactly one cycle
  - Mem_RD_Addr and Mem_WR_Addr both equal the latched address; Mem_Din equals the latched Wdata.
  - Mem_WE is 01/10/11 for SB/SH/SW and 00 for loads, decoded from the state so it is low outside ACCESS.
  - At the closing edge, memory performs the write. For loads, Rsp_Rdata captures the extended Mem_Dout.
  - Next state is RESP.
- RESP
  - Rsp_Valid=1; all Rsp_* outputs are stable.
  - On Rsp_Ready at an edge, clear Rsp_Valid and the flags, and go to IDLE.
  - Rsp_Ready while Rsp_Valid=0 is ignored.

Timing:
- Latency: request accepted at edge E0 gives Rsp_Valid high after E1, or after E0 on an error.
- Throughput: at most one request every 3 cycles.

Error rules, evaluated on the request fields in IDLE:
- Misaligned: halfword access with Addr[0]=1; word access with Addr[1:0]!=0.
- Fault: load funct3 of 3, 6 or 7; store funct3 of 3 or higher; or Addr + size - 1 >= MEM_BYTES. The range check uses 33-bit arithmetic so that 0xFFFFFFFF+3 does not wrap.
- If both misalignment and fault apply, both flags are set.

Load extension, taken from Mem_Dout bits [7:0] or [15:0]:
- LB: sign-extend bit 7.
- LH: sign-extend bit 15.
- LBU, LHU: zero-extend.
- LW: pass through.

Store data:
- Store data is passed unmodified. The memory uses only the low bytes indicated by Mem_WE.

Decomposition:
- Package lsu_pkg holds:
  - funct3 constants for LB, LH, LW, LBU, LHU, SB, SH, SW;
  - WE encodings WE_NONE, WE_BYTE, WE_HALF, WE_WORD;
  - the state encoding IDLE, ACCESS, RESP;
  - a function returning access size in bytes from funct3.
- Sub-module load_extend is combinational. Inputs are funct3[2:0] and raw[31:0]; output is ext[31:0]. It is instantiated once and is unit-testable on its own.

Test Plan:
- Word store/load round trip: SW Addr=0x10 Wdata=0xDEADBEEF → Mem_WE=11 for exactly one cycle, then Rsp_Valid. Then LW 0x10 → Rsp_Rdata=0xDEADBEEF, flags 0, Rsp_Valid 2 cycles after acceptance.
- Byte extension: with word 0x000080F0 at 0x20, LB 0x20 → 0xFFFFFFF0; LBU 0x20 → 0x000000F0; LH 0x20 → 0xFFFF80F0; LHU 0x20 → 0x000080F0.
- Misalignment: SH 0x21 and LW 0x22 → Rsp_Misaligned=1, Rdata=0, Mem_WE stays 00, Rsp_Valid 1 cycle after acceptance. Memory at 0x20 is unchanged on read-back.
- Range and illegal funct3: LW 0x3FC → OK. LW 0x3FD → misaligned and fault. LB 0x400 → fault. Store funct3=3 → fault. No write occurs in any error case.
- Backpressure: hold Rsp_Ready=0 for 5 cycles after an LW → Rsp_Valid and Rsp_Rdata stay stable and Req_Ready stays 0 throughout. Assert Rsp_Ready → IDLE on the next edge, and a queued Req_Valid is accepted the cycle after.
- Reset mid-store: assert Rst in the ACCESS cycle of SW 0x30 0x11223344 → Mem_WE goes to 00 combinationally, memory at 0x30 keeps its old value, and all outputs return to their reset values.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//
// Contents:
//   - RV32I funct3 codes for loads (LB/LH/LW/LBU/LHU) and stores (SB/SH/SW)
//   - the memory write-enable codes (Mem_WE)
//   - the FSM state encoding
//   - access_size(): access width in bytes for a funct3
package lsu_pkg;

    localparam logic [2:0] F3_LB  = 3'd0;
    localparam logic [2:0] F3_LH  = 3'd1;
    localparam logic [2:0] F3_LW  = 3'd2;
    localparam logic [2:0] F3_LBU = 3'd4;
    localparam logic [2:0] F3_LHU = 3'd5;
    localparam logic [2:0] F3_SB  = 3'd0;
    localparam logic [2:0] F3_SH  = 3'd1;
    localparam logic [2:0] F3_SW  = 3'd2;

    localparam logic [1:0] WE_NONE = 2'b00;
    localparam logic [1:0] WE_BYTE = 2'b01;
    localparam logic [1:0] WE_HALF = 2'b10;
    localparam logic [1:0] WE_WORD = 2'b11;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsu_state_t;

    // The low two funct3 bits carry the width for both loads and stores
    // (bit 2 only selects zero-extension). Illegal codes still get a size
    // here; they are rejected separately as faults.
    function automatic logic [2:0] access_size(input logic [2:0] funct3);
        case (funct3[1:0])
            2'b00:   access_size = 3'd1;
            2'b01:   access_size = 3'd2;
            2'b10:   access_size = 3'd4;
            default: access_size = 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load-data extender.
//
// Ports:
//   funct3 [2:0]  load funct3 (LB, LH, LW, LBU, LHU)
//   raw    [31:0] little-endian word read from memory
//   ext    [31:0] sign/zero-extended load result (0 for non-load codes)
module load_extend
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [31:0] raw,
    output logic [31:0] ext
);

    always_comb begin
        ext = '0;
        case (funct3)
            F3_LB:   ext = {{24{raw[7]}}, raw[7:0]};
            F3_LH:   ext = {{16{raw[15]}}, raw[15:0]};
            F3_LW:   ext = raw;
            F3_LBU:  ext = {24'd0, raw[7:0]};
            F3_LHU:  ext = {16'd0, raw[15:0]};
            default: ext = '0;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit between the execute stage and a byte-addressable
// data memory. One request is in flight at a time; errors are detected on
// the request fields and suppress the memory access entirely.
//
// Handshakes (both ports): a transfer happens at a rising edge where valid
// and ready are both high. The producer holds valid and its payload stable
// until that edge. Req_Ready is high only in IDLE; Rsp_Valid is high only
// in RESP, with all Rsp_* outputs held stable until accepted.
//
// Ports:
//   Clk, Rst                      clock, asynchronous active-high reset
//   Req_Valid/Req_Ready           request handshake
//   Req_Store, Req_Funct3,
//   Req_Addr, Req_Wdata           request payload
//   Rsp_Valid/Rsp_Ready           response handshake
//   Rsp_Rdata, Rsp_Misaligned,
//   Rsp_Fault                     response payload
//   Mem_RD_Addr, Mem_WR_Addr,
//   Mem_Din, Mem_WE, Mem_Dout     data memory interface
//   Dbg_State                     current FSM state (lsu_state_t encoding)
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 32
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Req_Valid,
    output logic              Req_Ready,
    input  logic              Req_Store,
    input  logic [2:0]        Req_Funct3,
    input  logic [ADDR_W-1:0] Req_Addr,
    input  logic [31:0]       Req_Wdata,
    output logic              Rsp_Valid,
    input  logic              Rsp_Ready,
    output logic [31:0]       Rsp_Rdata,
    output logic              Rsp_Misaligned,
    output logic              Rsp_Fault,
    output logic [ADDR_W-1:0] Mem_RD_Addr,
    output logic [ADDR_W-1:0] Mem_WR_Addr,
    output logic [31:0]       Mem_Din,
    output logic [1:0]        Mem_WE,
    input  logic [31:0]       Mem_Dout,
    output logic [1:0]        Dbg_State
);

    lsu_state_t        state_q, state_d;
    logic              store_q, store_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mis_q, mis_d;
    logic              fault_q, fault_d;

    // ------------------------------------------------------------------
    // Request error evaluation (purely on the incoming fields)
    // ------------------------------------------------------------------
    logic          req_legal;
    logic [2:0]    req_size;
    logic [ADDR_W:0] req_last;
    logic          req_mis;
    logic          req_fault;

    always_comb begin
        if (Req_Store) begin
            req_legal = (Req_Funct3 <= F3_SW);
        end else begin
            req_legal = (Req_Funct3 != 3'd3) && (Req_Funct3 != 3'd6) &&
                        (Req_Funct3 != 3'd7);
        end
        req_size = access_size(Req_Funct3);
        // One extra bit so an address near the top of the space cannot
        // wrap back into range.
        req_last = {1'b0, Req_Addr} + (ADDR_W+1)'(req_size) - (ADDR_W+1)'(1);
        // Alignment is only meaningful for a real access width.
        req_mis  = req_legal &&
                   (((req_size == 3'd2) && Req_Addr[0]) ||
                    ((req_size == 3'd4) && (Req_Addr[1:0] != 2'b00)));
        req_fault = !req_legal || (req_last >= (ADDR_W+1)'(MEM_BYTES));
    end

    // ------------------------------------------------------------------
    // Load extension of the memory read data
    // ------------------------------------------------------------------
    logic [31:0] load_ext;

    load_extend u_load_extend (
        .funct3 (funct3_q),
        .raw    (Mem_Dout),
        .ext    (load_ext)
    );

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q  <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            mis_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            store_q  <= store_d;
            funct3_q <= funct3_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            mis_q    <= mis_d;
            fault_q  <= fault_d;
        end
    end

    // ------------------------------------------------------------------
    // Next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        store_d   = store_q;
        funct3_d  = funct3_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        mis_d     = mis_q;
        fault_d   = fault_q;
        Req_Ready = 1'b0;
        Rsp_Valid = 1'b0;

        case (state_q)
            IDLE: begin
                Req_Ready = 1'b1;
                if (Req_Valid) begin
                    store_d  = Req_Store;
                    funct3_d = Req_Funct3;
                    addr_d   = Req_Addr;
                    wdata_d  = Req_Wdata;
                    rdata_d  = '0;
                    mis_d    = req_mis;
                    fault_d  = req_fault;
                    // Errored requests skip ACCESS so memory is never touched.
                    state_d  = (req_mis || req_fault) ? RESP : ACCESS;
                end
            end
            ACCESS: begin
                rdata_d = store_q ? 32'd0 : load_ext;
                state_d = RESP;
            end
            RESP: begin
                Rsp_Valid = 1'b1;
                if (Rsp_Ready) begin
                    mis_d   = 1'b0;
                    fault_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Write enable is decoded from the state register, so an asynchronous
    // reset during ACCESS removes it before the closing edge.
    always_comb begin
        Mem_WE = WE_NONE;
        if ((state_q == ACCESS) && store_q) begin
            case (funct3_q[1:0])
                2'b00:   Mem_WE = WE_BYTE;
                2'b01:   Mem_WE = WE_HALF;
                2'b10:   Mem_WE = WE_WORD;
                default: Mem_WE = WE_NONE;
            endcase
        end
    end

    assign Mem_RD_Addr    = addr_q;
    assign Mem_WR_Addr    = addr_q;
    assign Mem_Din        = wdata_q;
    assign Rsp_Rdata      = rdata_q;
    assign Rsp_Misaligned = mis_q;
    assign Rsp_Fault      = fault_q;
    assign Dbg_State      = state_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a 1 KB byte-array memory model.
module tb_load_store_unit;

    logic        Clk = 1'b0;
    logic        Rst = 1'b1;
    logic        Req_Valid = 1'b0;
    logic        Req_Ready;
    logic        Req_Store = 1'b0;
    logic [2:0]  Req_Funct3 = 3'd0;
    logic [31:0] Req_Addr = 32'd0;
    logic [31:0] Req_Wdata = 32'd0;
    logic        Rsp_Valid;
    logic        Rsp_Ready = 1'b0;
    logic [31:0] Rsp_Rdata;
    logic        Rsp_Misaligned;
    logic        Rsp_Fault;
    logic [31:0] Mem_RD_Addr;
    logic [31:0] Mem_WR_Addr;
    logic [31:0] Mem_Din;
    logic [1:0]  Mem_WE;
    logic [31:0] Mem_Dout;
    logic [1:0]  Dbg_State;

    int tests_run = 0;
    int tests_failed = 0;

    load_store_unit #(.MEM_BYTES(1024), .ADDR_W(32)) dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .Req_Valid      (Req_Valid),
        .Req_Ready      (Req_Ready),
        .Req_Store      (Req_Store),
        .Req_Funct3     (Req_Funct3),
        .Req_Addr       (Req_Addr),
        .Req_Wdata      (Req_Wdata),
        .Rsp_Valid      (Rsp_Valid),
        .Rsp_Ready      (Rsp_Ready),
        .Rsp_Rdata      (Rsp_Rdata),
        .Rsp_Misaligned (Rsp_Misaligned),
        .Rsp_Fault      (Rsp_Fault),
        .Mem_RD_Addr    (Mem_RD_Addr),
        .Mem_WR_Addr    (Mem_WR_Addr),
        .Mem_Din        (Mem_Din),
        .Mem_WE         (Mem_WE),
        .Mem_Dout       (Mem_Dout),
        .Dbg_State      (Dbg_State)
    );

    // ---------------- clock ----------------
    always #5 Clk = ~Clk;

    // ---------------- memory model ----------------
    logic [7:0] mem [1024];
    logic [9:0] ra, wa;
    assign ra = Mem_RD_Addr[9:0];
    assign wa = Mem_WR_Addr[9:0];
    assign Mem_Dout = {mem[ra + 10'd3], mem[ra + 10'd2], mem[ra + 10'd1], mem[ra]};

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    end

    always @(posedge Clk) begin
        case (Mem_WE)
            2'b01: mem[wa] <= Mem_Din[7:0];
            2'b10: begin
                mem[wa]         <= Mem_Din[7:0];
                mem[wa + 10'd1] <= Mem_Din[15:8];
            end
            2'b11: begin
                mem[wa]         <= Mem_Din[7:0];
                mem[wa + 10'd1] <= Mem_Din[15:8];
                mem[wa + 10'd2] <= Mem_Din[23:16];
                mem[wa + 10'd3] <= Mem_Din[31:24];
            end
            default: ;
        endcase
    end

    // ---------------- write-enable monitor ----------------
    int         we_cnt = 0;
    logic [1:0] last_we = 2'b00;
    always @(negedge Clk) begin
        if (Mem_WE != 2'b00) begin
            we_cnt  = we_cnt + 1;
            last_we = Mem_WE;
        end
    end

    // ---------------- vector type ----------------
    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        mis;
        logic        flt;
        logic [3:0]  lat;
        logic [3:0]  wen;
        logic [1:0]  wev;
    } vec_t;

    // ---------------- driver ----------------
    // Issues one request, measures edges from acceptance to Rsp_Valid,
    // captures the response and completes the handshake.
    task automatic do_access(input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             output int lat, output logic [31:0] rdata,
                             output logic mis, output logic flt,
                             output int wen, output logic [1:0] wev);
        int w;
        int base;
        w = 0;
        while (!Req_Ready && w < 20) begin
            @(posedge Clk); #1;
            w++;
        end
        if (w >= 20) begin
            tests_run++;
            tests_failed++;
            $display("FAIL req_ready_wait: Req_Ready stayed %b, need 1", Req_Ready);
        end
        last_we    = 2'b00;
        base       = we_cnt;
        Req_Valid  = 1'b1;
        Req_Store  = st;
        Req_Funct3 = f3;
        Req_Addr   = addr;
        Req_Wdata  = wdata;
        @(posedge Clk); #1;
        Req_Valid  = 1'b0;
        lat = 0;
        while (!Rsp_Valid && lat < 10) begin
            @(posedge Clk); #1;
            lat++;
        end
        if (lat >= 10) begin
            tests_run++;
            tests_failed++;
            $display("FAIL rsp_valid_wait: Rsp_Valid stayed %b, need 1", Rsp_Valid);
        end
        rdata = Rsp_Rdata;
        mis   = Rsp_Misaligned;
        flt   = Rsp_Fault;
        wen   = we_cnt - base;
        wev   = last_we;
        Rsp_Ready = 1'b1;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
    endtask

    int          o_lat, o_wen;
    logic [31:0] o_rd;
    logic        o_mis, o_flt;
    logic [1:0]  o_wev;

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(posedge Clk);
        #1;
        tests_run++;
        if ({Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Misaligned, Rsp_Fault, Mem_WE, Mem_RD_Addr, Mem_Din}
            !== {1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 2'b00, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL reset_held: got rdy=%b vld=%b rd=%h mis=%b flt=%b we=%b ra=%h din=%h, want 1 0 0 0 0 00 0 0",
                     Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Misaligned, Rsp_Fault, Mem_WE, Mem_RD_Addr, Mem_Din);
        end
        Rst = 1'b0;
        @(posedge Clk); #1;
        tests_run++;
        if ({Req_Ready, Rsp_Valid, Mem_WE} !== {1'b1, 1'b0, 2'b00}) begin
            tests_failed++;
            $display("FAIL reset_release: got rdy=%b vld=%b we=%b, want 1 0 00", Req_Ready, Rsp_Valid, Mem_WE);
        end
    endtask

    // Runs a vector table; the name identifies the scenario in FAIL lines.
    task automatic test_vectors(input string name, input vec_t v[], input int n);
        for (int i = 0; i < n; i++) begin
            do_access(v[i].st, v[i].f3, v[i].addr, v[i].wdata, o_lat, o_rd, o_mis, o_flt, o_wen, o_wev);
            tests_run++;
            if ({o_lat[3:0], o_rd, o_mis, o_flt, o_wen[3:0], o_wev}
                !== {v[i].lat, v[i].rdata, v[i].mis, v[i].flt, v[i].wen, v[i].wev}) begin
                tests_failed++;
                $display("FAIL %s[%0d]: got lat=%0d rdata=%h mis=%b flt=%b we_cycles=%0d we=%b, want lat=%0d rdata=%h mis=%b flt=%b we_cycles=%0d we=%b",
                         name, i, o_lat, o_rd, o_mis, o_flt, o_wen, o_wev,
                         v[i].lat, v[i].rdata, v[i].mis, v[i].flt, v[i].wen, v[i].wev);
            end
        end
    endtask

    task automatic test_word_roundtrip();
        vec_t v[] = new[2];
        v[0] = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b11};
        v[1] = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        test_vectors("word_roundtrip", v, 2);
    endtask

    task automatic test_byte_extension();
        vec_t v[] = new[8];
        v[0] = '{1'b1, 3'd2, 32'h20, 32'h000080F0, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b11};
        v[1] = '{1'b0, 3'd0, 32'h20, 32'h0,        32'hFFFFFFF0, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[2] = '{1'b0, 3'd4, 32'h20, 32'h0,        32'h000000F0, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[3] = '{1'b0, 3'd1, 32'h20, 32'h0,        32'hFFFF80F0, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[4] = '{1'b0, 3'd5, 32'h20, 32'h0,        32'h000080F0, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[5] = '{1'b0, 3'd0, 32'h21, 32'h0,        32'hFFFFFF80, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[6] = '{1'b0, 3'd4, 32'h21, 32'h0,        32'h00000080, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[7] = '{1'b0, 3'd1, 32'h22, 32'h0,        32'h00000000, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        test_vectors("byte_extension", v, 8);
    endtask

    task automatic test_partial_store();
        vec_t v[] = new[4];
        v[0] = '{1'b1, 3'd2, 32'h50, 32'h55667788, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b11};
        v[1] = '{1'b1, 3'd1, 32'h52, 32'hAAAABBBB, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b10};
        v[2] = '{1'b1, 3'd0, 32'h51, 32'h00000011, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b01};
        v[3] = '{1'b0, 3'd2, 32'h50, 32'h0,        32'hBBBB1188, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        test_vectors("partial_store", v, 4);
    endtask

    task automatic test_misalign();
        vec_t v[] = new[4];
        v[0] = '{1'b1, 3'd1, 32'h21, 32'h0000FFFF, 32'h0,        1'b1, 1'b0, 4'd0, 4'd0, 2'b00};
        v[1] = '{1'b0, 3'd2, 32'h22, 32'h0,        32'h0,        1'b1, 1'b0, 4'd0, 4'd0, 2'b00};
        v[2] = '{1'b0, 3'd5, 32'h23, 32'h0,        32'h0,        1'b1, 1'b0, 4'd0, 4'd0, 2'b00};
        v[3] = '{1'b0, 3'd2, 32'h20, 32'h0,        32'h000080F0, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        test_vectors("misalign", v, 4);
    endtask

    task automatic test_range();
        vec_t v[] = new[12];
        v[0]  = '{1'b1, 3'd2, 32'h3FC,      32'h0BADCAFE, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b11};
        v[1]  = '{1'b1, 3'd0, 32'h3FF,      32'h000000A5, 32'h0,        1'b0, 1'b0, 4'd1, 4'd1, 2'b01};
        v[2]  = '{1'b0, 3'd2, 32'h3FC,      32'h0,        32'hA5ADCAFE, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[3]  = '{1'b0, 3'd5, 32'h3FE,      32'h0,        32'h0000A5AD, 1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        v[4]  = '{1'b0, 3'd2, 32'h3FD,      32'h0,        32'h0,        1'b1, 1'b1, 4'd0, 4'd0, 2'b00};
        v[5]  = '{1'b0, 3'd0, 32'h400,      32'h0,        32'h0,        1'b0, 1'b1, 4'd0, 4'd0, 2'b00};
        v[6]  = '{1'b1, 3'd3, 32'h40,       32'h12345678, 32'h0,        1'b0, 1'b1, 4'd0, 4'd0, 2'b00};
        v[7]  = '{1'b1, 3'd4, 32'h40,       32'h12345678, 32'h0,        1'b0, 1'b1, 4'd0, 4'd0, 2'b00};
        v[8]  = '{1'b0, 3'd6, 32'h40,       32'h0,        32'h0,        1'b0, 1'b1, 4'd0, 4'd0, 2'b00};
        v[9]  = '{1'b0, 3'd2, 32'hFFFFFFFC, 32'h0,        32'h0,        1'b0, 1'b1, 4'd0, 4'd0, 2'b00};
        v[10] = '{1'b1, 3'd1, 32'h3FF,      32'h0000BEEF, 32'h0,        1'b1, 1'b1, 4'd0, 4'd0, 2'b00};
        v[11] = '{1'b0, 3'd2, 32'h40,       32'h0,        32'h0,        1'b0, 1'b0, 4'd1, 4'd0, 2'b00};
        test_vectors("range", v, 12);
    endtask

    task automatic test_backpressure();
        Req_Valid  = 1'b1;
        Req_Store  = 1'b0;
        Req_Funct3 = 3'd2;
        Req_Addr   = 32'h10;
        Req_Wdata  = 32'h0;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        @(posedge Clk); #1;
        for (int i = 0; i < 5; i++) begin
            tests_run++;
            if ({Rsp_Valid, Rsp_Rdata, Req_Ready} !== {1'b1, 32'hDEADBEEF, 1'b0}) begin
                tests_failed++;
                $display("FAIL backpressure_hold[%0d]: got vld=%b rd=%h rdy=%b, want 1 deadbeef 0",
                         i, Rsp_Valid, Rsp_Rdata, Req_Ready);
            end
            @(posedge Clk); #1;
        end
        // Release the response with the next request already queued.
        Rsp_Ready  = 1'b1;
        Req_Valid  = 1'b1;
        Req_Funct3 = 3'd4;
        Req_Addr   = 32'h20;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
        tests_run++;
        if ({Rsp_Valid, Req_Ready} !== {1'b0, 1'b1}) begin
            tests_failed++;
            $display("FAIL backpressure_release: got vld=%b rdy=%b, want 0 1", Rsp_Valid, Req_Ready);
        end
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        tests_run++;
        if ({Rsp_Valid, Req_Ready} !== {1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL backpressure_accept: got vld=%b rdy=%b, want 0 0", Rsp_Valid, Req_Ready);
        end
        @(posedge Clk); #1;
        tests_run++;
        if ({Rsp_Valid, Rsp_Rdata} !== {1'b1, 32'h000000F0}) begin
            tests_failed++;
            $display("FAIL backpressure_next_rsp: got vld=%b rd=%h, want 1 000000f0", Rsp_Valid, Rsp_Rdata);
        end
        Rsp_Ready = 1'b1;
        @(posedge Clk); #1;
        Rsp_Ready = 1'b0;
    endtask

    task automatic test_reset_mid_store();
        do_access(1'b1, 3'd2, 32'h30, 32'hCAFEF00D, o_lat, o_rd, o_mis, o_flt, o_wen, o_wev);
        tests_run++;
        if ({o_lat[3:0], o_wen[3:0], o_wev} !== {4'd1, 4'd1, 2'b11}) begin
            tests_failed++;
            $display("FAIL mid_reset_preload: got lat=%0d we_cycles=%0d we=%b, want 1 1 11", o_lat, o_wen, o_wev);
        end
        Req_Valid  = 1'b1;
        Req_Store  = 1'b1;
        Req_Funct3 = 3'd2;
        Req_Addr   = 32'h30;
        Req_Wdata  = 32'h11223344;
        @(posedge Clk); #1;
        Req_Valid = 1'b0;
        tests_run++;
        if (Mem_WE !== 2'b11) begin
            tests_failed++;
            $display("FAIL mid_reset_access_we: got %b, want 11", Mem_WE);
        end
        Rst = 1'b1;
        #1;
        tests_run++;
        if ({Mem_WE, Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Misaligned, Rsp_Fault, Mem_RD_Addr, Mem_WR_Addr, Mem_Din}
            !== {2'b00, 1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd0, 32'd0, 32'd0}) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got we=%b rdy=%b vld=%b rd=%h mis=%b flt=%b ra=%h wa=%h din=%h, want 00 1 0 0 0 0 0 0 0",
                     Mem_WE, Req_Ready, Rsp_Valid, Rsp_Rdata, Rsp_Misaligned, Rsp_Fault, Mem_RD_Addr, Mem_WR_Addr, Mem_Din);
        end
        @(posedge Clk); #1;
        Rst = 1'b0;
        @(posedge Clk); #1;
        do_access(1'b0, 3'd2, 32'h30, 32'h0, o_lat, o_rd, o_mis, o_flt, o_wen, o_wev);
        tests_run++;
        if ({o_rd, o_mis, o_flt} !== {32'hCAFEF00D, 1'b0, 1'b0}) begin
            tests_failed++;
            $display("FAIL mid_reset_readback: got rd=%h mis=%b flt=%b, want cafef00d 0 0", o_rd, o_mis, o_flt);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_word_roundtrip();
        test_byte_extension();
        test_partial_store();
        test_misalign();
        test_range();
        test_backpressure();
        test_reset_mid_store();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
